// File: rtl/prog_counter.sv
// prog_counter: programmable up/down counter with limit compare and free-run,
// auto-reload and one-shot terminal-count modes.
module prog_counter #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] lmt,
  input  logic [1:0]       mode,
  input  logic             clr_done,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt,
  output logic             wrap,
  output logic             done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] step_val;
  logic             tc_nxt, evt_nxt, wrap_nxt;
  logic             take, hit;
  logic             is_reload, is_oneshot;

  always_comb begin
    // Mode 11 behaves exactly like free-run.
    is_reload  = (mode == 2'b01);
    is_oneshot = (mode == 2'b10);
    take       = en && !(is_oneshot && (state == DONE));
    hit        = take && (count == lmt);
    step_val   = up ? (count + ONE) : (count - ONE);

    count_nxt = count;
    state_nxt = state;
    evt_nxt   = 1'b0;
    wrap_nxt  = 1'b0;

    if (load) begin
      count_nxt = data;
      state_nxt = RUN;
    end else begin
      if (take) begin
        if (hit && is_reload) begin
          count_nxt = data;
        end else if (!(hit && is_oneshot)) begin
          count_nxt = step_val;
          wrap_nxt  = up ? (&count) : (~|count);
        end
      end
      evt_nxt = hit;
      // A terminal event in one-shot outranks a same-cycle clear.
      if (hit && is_oneshot) begin
        state_nxt = DONE;
      end else if (clr_done) begin
        state_nxt = RUN;
      end
    end

    tc_nxt = (count_nxt == lmt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= RESET_VAL;
      tc    <= 1'b0;
      evt   <= 1'b0;
      wrap  <= 1'b0;
      state <= RUN;
    end else begin
      count <= count_nxt;
      tc    <= tc_nxt;
      evt   <= evt_nxt;
      wrap  <= wrap_nxt;
      state <= state_nxt;
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: directed vectors with literal checks
// plus an arithmetic reference model compared every cycle on two instances.
module tb_prog_counter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, load, en, up, clr_done;
  logic [W-1:0] data, lmt;
  logic [1:0]   mode;

  logic [W-1:0] d_count [2];
  logic         d_tc [2];
  logic         d_evt [2];
  logic         d_wrap [2];
  logic         d_done [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prog_counter #(.WIDTH(W), .RESET_VAL(8'h00)) dut0 (
    .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
    .lmt(lmt), .mode(mode), .clr_done(clr_done),
    .count(d_count[0]), .tc(d_tc[0]), .evt(d_evt[0]), .wrap(d_wrap[0]), .done(d_done[0])
  );

  prog_counter #(.WIDTH(W), .RESET_VAL(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .load(load), .data(data), .en(en), .up(up),
    .lmt(lmt), .mode(mode), .clr_done(clr_done),
    .count(d_count[1]), .tc(d_tc[1]), .evt(d_evt[1]), .wrap(d_wrap[1]), .done(d_done[1])
  );

  // Reference model: plain integer arithmetic modulo 256.
  int rv [2] = '{0, 'hA5};
  int m_count [2];
  int m_tc [2];
  int m_evt [2];
  int m_wrap [2];
  int m_done [2];
  bit started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int md, nxt;
      bit take, hit;
      if (reset) begin
        m_count[i] = rv[i]; m_tc[i] = 0; m_evt[i] = 0; m_wrap[i] = 0; m_done[i] = 0;
      end else if (load) begin
        m_count[i] = int'(data); m_done[i] = 0; m_evt[i] = 0; m_wrap[i] = 0;
      end else begin
        md   = (mode == 2'd3) ? 0 : int'(mode);
        take = en && !(md == 2 && m_done[i] == 1);
        hit  = take && (m_count[i] == int'(lmt));
        m_evt[i]  = hit ? 1 : 0;
        m_wrap[i] = 0;
        if (take) begin
          nxt = up ? (m_count[i] + 1) % 256 : (m_count[i] + 255) % 256;
          if (hit && md == 1)      m_count[i] = int'(data);
          else if (hit && md == 2) m_count[i] = m_count[i];
          else begin
            m_wrap[i]  = (up && m_count[i] == 255) || (!up && m_count[i] == 0) ? 1 : 0;
            m_count[i] = nxt;
          end
        end
        if (hit && md == 2)  m_done[i] = 1;
        else if (clr_done)   m_done[i] = 0;
      end
      if (!reset) m_tc[i] = (m_count[i] == int'(lmt)) ? 1 : 0;
    end
    started = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model count[%0d]", i), 32'(d_count[i]), 32'(m_count[i]));
        check($sformatf("model tc[%0d]", i),    32'(d_tc[i]),    32'(m_tc[i]));
        check($sformatf("model evt[%0d]", i),   32'(d_evt[i]),   32'(m_evt[i]));
        check($sformatf("model wrap[%0d]", i),  32'(d_wrap[i]),  32'(m_wrap[i]));
        check($sformatf("model done[%0d]", i),  32'(d_done[i]),  32'(m_done[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal check on instance 0: count, tc, evt, wrap, done.
  task automatic lit(input string name, input logic [7:0] c, input logic t,
                     input logic e, input logic w, input logic d);
    check({name, " count"}, 32'(d_count[0]), 32'(c));
    check({name, " tc"},    32'(d_tc[0]),    32'(t));
    check({name, " evt"},   32'(d_evt[0]),   32'(e));
    check({name, " wrap"},  32'(d_wrap[0]),  32'(w));
    check({name, " done"},  32'(d_done[0]),  32'(d));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; en = 1'b0; up = 1'b1; clr_done = 1'b0;
    data = '0; lmt = 8'h80; mode = 2'b00;
    tick(); tick();
    lit("reset", 8'h00, 0, 0, 0, 0);
    check("reset count inst1", 32'(d_count[1]), 32'h0A5);

    // Load then count up three times.
    reset = 1'b0; load = 1'b1; data = 8'h10;
    tick();
    lit("load", 8'h10, 0, 0, 0, 0);
    load = 1'b0; en = 1'b1;
    tick(); lit("up1", 8'h11, 0, 0, 0, 0);
    tick(); lit("up2", 8'h12, 0, 0, 0, 0);
    tick(); lit("up3", 8'h13, 0, 0, 0, 0);

    // Free-run wrap at lmt = 0xFF.
    en = 1'b0; load = 1'b1; data = 8'hFE; lmt = 8'hFF;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); lit("fr ff", 8'hFF, 1, 0, 0, 0);
    tick(); lit("fr wrap", 8'h00, 0, 1, 1, 0);
    tick(); lit("fr after", 8'h01, 0, 0, 0, 0);
    en = 1'b0;
    tick(); lit("en off", 8'h01, 0, 0, 0, 0);

    // Auto-reload counting down.
    mode = 2'b01; up = 1'b0; data = 8'd5; lmt = 8'd2; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); lit("ar 4", 8'd4, 0, 0, 0, 0);
    tick(); lit("ar 3", 8'd3, 0, 0, 0, 0);
    tick(); lit("ar 2", 8'd2, 1, 0, 0, 0);
    tick(); lit("ar reload", 8'd5, 0, 1, 0, 0);
    tick(); lit("ar 4b", 8'd4, 0, 0, 0, 0);

    // One-shot.
    en = 1'b0; mode = 2'b10; up = 1'b1; data = 8'd0; lmt = 8'd3; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); tick();
    tick(); lit("os at lmt", 8'd3, 1, 0, 0, 0);
    tick(); lit("os fire", 8'd3, 1, 1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      tick(); lit("os hold", 8'd3, 1, 0, 0, 1);
    end
    clr_done = 1'b1;
    tick(); lit("os clr", 8'd3, 1, 0, 0, 0);
    clr_done = 1'b0;
    tick(); lit("os refire", 8'd3, 1, 1, 0, 1);

    // Clear on the terminal-event cycle: set wins.
    clr_done = 1'b1;
    tick(); lit("clr", 8'd3, 1, 0, 0, 0);
    tick(); lit("clr+evt", 8'd3, 1, 1, 0, 1);
    clr_done = 1'b0;

    // Load and enable at the terminal value: load wins.
    load = 1'b1; data = 8'd3;
    tick(); lit("load only", 8'd3, 1, 0, 0, 0);
    tick(); lit("load+en", 8'd3, 1, 0, 0, 0);
    load = 1'b0;

    // Reset mid-operation with count 0x37 and done set.
    data = 8'h36; lmt = 8'h37; load = 1'b1;
    tick();
    load = 1'b0;
    tick(); tick(); lit("pre reset", 8'h37, 1, 1, 0, 1);
    reset = 1'b1;
    tick(); lit("mid reset", 8'h00, 0, 0, 0, 0);
    check("mid reset count inst1", 32'(d_count[1]), 32'h0A5);
    check("mid reset done inst1", 32'(d_done[1]), 32'h0);
    reset = 1'b0; en = 1'b0;
    tick();

    // Mixed stimulus checked against the model only.
    for (int k = 0; k < 400; k++) begin
      reset    = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 11) == 0);
      en       = ($urandom_range(0, 4) != 0);
      up       = ($urandom_range(0, 3) != 0);
      clr_done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
      data = $urandom_range(0, 1) ? 8'($urandom_range(0, 3)) : 8'(8'hFC + $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) lmt = 8'($urandom_range(0, 4));
      tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised programmable counter for the ADC interface timing path. It generalises the fixed 32-bit load/enable counter with limit compare: configurable width, up/down direction, and three terminal-count modes (free-run, auto-reload, one-shot). It adds a terminal-event pulse, a wrap pulse and a sticky done flag. Everything is on the rising edge of `clk`; there is no negedge logic. It drives ADC conversion-start spacing and sample-window timing.

## Interface
Parameters:
- `WIDTH`, 32, counter/data/limit width in bits (≥ 2)
- `RESET_VAL`, 0, value loaded into `count` on reset (WIDTH bits)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `load`  in  1  load `data` into `count`
- `data`  in  WIDTH  load value; also the reload value in auto-reload mode
- `en`  in  1  count enable (one step per cycle)
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `lmt`  in  WIDTH  terminal value compared against `count`
- `mode`  in  2  00 free-run, 01 auto-reload, 10 one-shot, 11 treated as 00
- `clr_done`  in  1  clears `done`
- `count`  out  WIDTH  current count (registered)
- `tc`  out  1  registered: 1 when `count == lmt`
- `evt`  out  1  one-cycle pulse on each terminal event
- `wrap`  out  1  one-cycle pulse when a step crosses the max/0 boundary
- `done`  out  1  sticky; set by a terminal event in one-shot mode

## Operation
- Priority at each edge: `reset` > `load` > enabled step.
- Reset: `count`=RESET_VAL, `tc`=0, `evt`=0, `wrap`=0, `done`=0.
- Load: `count`←`data`, `done`←0, `evt`←0, `wrap`←0. `en`, `mode` and `clr_done` are ignored that cycle.
- Step: taken when `en`=1 and not (mode=10 and `done`=1). It is `count±1` modulo 2^WIDTH.
- A terminal event is a step taken while `count == lmt`, using `lmt` sampled at that edge:
  - free-run: normal step; `evt`←1.
  - auto-reload: `count`←`data` instead of stepping; `evt`←1; no `wrap`.
  - one-shot: `count` holds at `lmt`; `evt`←1; `done`←1.
- `wrap`←1 only on a normal step from all-ones to 0 (up) or from 0 to all-ones (down).
- One-shot state machine:
  - RUN→DONE on a terminal event.
  - DONE→RUN on `clr_done` or `load`.
  - In DONE, `en` is ignored and `count` holds.
- `clr_done` with a same-cycle terminal event: the set wins, so `done` stays 1.
- `clr_done` in RUN, or in other modes: `done`←0 (no other effect).
- After `clr_done` in one-shot with `count` still equal to `lmt`, the next enabled cycle fires again.
- `en`=0: `count` holds; `evt` and `wrap` are 0.
- `mode` or `up` changes take effect on the next step; no state is flushed.

## Timing
- `count`, `evt`, `wrap` and `done` update at the same edge as the step that causes them. Latency is 1 cycle from the `en`/`load` sample to the output.
- `tc` is registered as (next `count` == `lmt`) at each edge, so it is aligned with `count`. A change on `lmt` alone is reflected in `tc` one cycle later.
- `evt` and `wrap` are never high for two consecutive cycles unless a step is taken in each of those cycles.
- Reset mid-count aborts immediately. Outputs take their reset values at that edge and counting resumes only after `reset` deasserts.

## Test plan
- Reset then load: with WIDTH=8, `load` `data`=0x10, then `en` for 3 cycles → `count` = 0x11, 0x12, 0x13; all outputs are 0 during reset.
- Free-run wrap: WIDTH=8, load 0xFE, `up`=1, `lmt`=0xFF, `en`=1 → `count` 0xFF with `tc`=1, then 0x00 with `evt`=1 and `wrap`=1, then 0x01 with both 0.
- Auto-reload, down: mode=01, `up`=0, load 5, `lmt`=2, `data`=5 → `count` 4, 3, 2, 5, 4, …; `evt` pulses on the 2→5 transition; `wrap` never asserts.
- One-shot: mode=10, load 0, `lmt`=3, `en`=1 → `count` stops at 3, `done`=1 and a single `evt`. Holding `en` for 5 more cycles keeps `count`=3. Then `clr_done` → `done`=0, and the next enabled cycle gives `evt`=1 and `done`=1 again.
- Simultaneous events: `load` and `en` at a terminal value → the load wins with `evt`=0. `clr_done` on the terminal-event cycle → `done`=1.
- Reset mid-operation: assert `reset` while `count`=0x37 and `done`=1 → next edge gives `count`=RESET_VAL and all flags 0. Repeat with RESET_VAL=0xA5.
